ror_amt_encoder: RTL

Sequential front-end for the 16-bit base-3 rotate-right stage. It accepts an operand, a 4-bit binary rotate amount and a direction flag over a valid/ready handshake. It converts the effective right-rotate amount into three 2-bit trits, one trit per cycle, and presents the operand plus the 6-bit base-3 code on a registered, back-pressurable output. That output drives the rotator's `a` and `base3_b` inputs directly.

---
 rtl/ror_amt_encoder_if.sv | 23 ++
 rtl/ror_amt_encoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/ror_amt_encoder_if.sv
// Handshake bundle between a request source, the base-3 amount encoder and the rotator.
// The slave modport is the encoder's view; the master modport is the driving side.
interface ror_amt_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [3:0]  in_amt;
  logic        in_rol;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a;
  logic [5:0]  out_base3_b;

  modport slave (
    input  in_valid, in_a, in_amt, in_rol, out_ready,
    output in_ready, out_valid, out_a, out_base3_b
  );

  modport master (
    output in_valid, in_a, in_amt, in_rol, out_ready,
    input  in_ready, out_valid, out_a, out_base3_b
  );
endinterface

// File: rtl/ror_amt_encoder.sv
// Converts a 4-bit rotate amount/direction into a right-rotate amount encoded as three
// base-3 trits, one trit per cycle, and holds operand plus code until consumed.
module ror_amt_encoder (
  input  logic                  clk,
  input  logic                  rst,
  ror_amt_encoder_if.slave      bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV0 = 3'd1,
    CONV1 = 3'd2,
    CONV2 = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] opnd_q, opnd_d;
  logic [3:0]  r_q, r_d;
  logic [1:0]  t0_q, t0_d;
  logic [1:0]  t1_q, t1_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_a_q, out_a_d;
  logic [5:0]  out_b_q, out_b_d;

  logic [3:0]  eff;
  logic [3:0]  r_div3;
  logic [3:0]  r_mod3;

  // Left rotate by n equals right rotate by (16 - n) mod 16, i.e. the 4-bit negate.
  assign eff    = bus.in_rol ? (4'd0 - bus.in_amt) : bus.in_amt;
  assign r_div3 = r_q / 4'd3;
  assign r_mod3 = r_q % 4'd3;

  always_comb begin
    state_d     = state_q;
    opnd_d      = opnd_q;
    r_d         = r_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opnd_d  = bus.in_a;
          r_d     = eff;
          state_d = CONV0;
        end
      end
      CONV0: begin
        t0_d    = r_mod3[1:0];
        r_d     = r_div3;
        state_d = CONV1;
      end
      CONV1: begin
        t1_d    = r_mod3[1:0];
        r_d     = r_div3;
        state_d = CONV2;
      end
      CONV2: begin
        out_a_d     = opnd_q;
        out_b_d     = {r_mod3[1:0], t1_q, t0_q};
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      opnd_q      <= '0;
      r_q         <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      r_q         <= r_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = out_valid_q;
  assign bus.out_a       = out_a_q;
  assign bus.out_base3_b = out_b_q;

endmodule
